// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: fetch FSM states, IF/ID bundle and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.pc       = 32'h0000_0000;
    b.pc_plus4 = 32'h0000_0000;
    b.instr    = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush inserts a bubble and takes priority over hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_flush,
  input  logic   i_hold,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= if_id_bubble();
    end else if (i_flush) begin
      r_q <= if_id_bubble();
    end else if (i_hold) begin
      r_q <= r_q;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and RUN/HALT/FAULT control
// feeding the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_halted;
  logic         r_fault;

  logic [31:0]  w_pc_plus4;
  logic         w_misalign;
  logic         w_flush;
  logic         w_hold;
  if_id_t       w_d;
  if_id_t       w_q;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    w_flush = 1'b0;
    w_hold  = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect) begin
          w_flush = 1'b1;
        end else if (stall) begin
          w_hold = 1'b1;
        end else begin
          w_flush = 1'b0;
        end
      end
      default: w_flush = 1'b1;
    endcase
  end

  assign w_d = '{valid: 1'b1, pc: r_pc, pc_plus4: w_pc_plus4, instr: imem_data};

  // A misaligned redirect faults without moving the PC; FAULT only leaves on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_misalign) begin
            r_state  <= FAULT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else if (redirect) begin
            r_pc <= redirect_pc;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (halt_req) begin
            r_pc     <= w_pc_plus4;
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_pc_plus4;
          end
        end
        HALT: begin
          if (w_misalign) begin
            r_state  <= FAULT;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_state  <= RUN;
            r_halted <= 1'b0;
          end else begin
            r_pc <= r_pc;
          end
        end
        FAULT: begin
          r_pc <= r_pc;
        end
        default: begin
          r_state  <= FAULT;
          r_halted <= 1'b1;
          r_fault  <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_hold  (w_hold),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign imem_addr   = r_pc;
  assign if_valid    = w_q.valid;
  assign if_pc       = w_q.pc;
  assign if_pc_plus4 = w_q.pc_plus4;
  assign if_instr    = w_q.instr;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a small combinational ROM.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;

  logic [31:0] imem_addr, imem_data;
  logic        if_valid, halted, fault;
  logic [31:0] if_pc, if_pc_plus4, if_instr;

  logic [31:0] imem_addr2, imem_data2;
  logic        if_valid2, halted2, fault2;
  logic [31:0] if_pc2, if_pc_plus42, if_instr2;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h8C00_0000;
      32'h0000_0004: rom = 32'h2001_0005;
      32'h0000_0008: rom = 32'h2002_0005;
      32'h0000_000C: rom = 32'h0022_1820;
      default:       rom = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  assign imem_data  = rom(imem_addr);
  assign imem_data2 = rom(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .halted(halted), .fault(fault)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .if_valid(if_valid2), .if_pc(if_pc2),
    .if_pc_plus4(if_pc_plus42), .if_instr(if_instr2), .halted(halted2), .fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", halted, fault); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h8C00_0000; exp_instr[1] = 32'h2001_0005;
    exp_instr[2] = 32'h2002_0005; exp_instr[3] = 32'h0022_1820;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_pc_plus4 !== 32'(4 * i + 4) ||
          if_instr !== exp_instr[i] || imem_addr !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL fetch[%0d] got v=%b pc=%h p4=%h ins=%h addr=%h exp v=1 pc=%h p4=%h ins=%h addr=%h",
                 i, if_valid, if_pc, if_pc_plus4, if_instr, imem_addr,
                 32'(4 * i), 32'(4 * i + 4), exp_instr[i], 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h2001_0005 || imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall[%0d] got pc=%h ins=%h addr=%h exp pc=4 ins=20010005 addr=8", i, if_pc, if_instr, imem_addr);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (if_pc !== 32'h8 || if_instr !== 32'h2002_0005 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume got pc=%h ins=%h exp pc=8 ins=20020005", if_pc, if_instr);
    end
  endtask

  task automatic test_redirect();
    step(); step();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL redir_pre got=%h exp=14", imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h18;
    step();
    redirect = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_addr !== 32'h18) begin
      errors++;
      $display("FAIL redir_bubble got v=%b ins=%h addr=%h exp v=0 ins=0 addr=18", if_valid, if_instr, imem_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h18 || if_pc_plus4 !== 32'h1C || if_instr !== 32'hDEAD_0018) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%h p4=%h ins=%h exp v=1 pc=18 p4=1c ins=dead0018", if_valid, if_pc, if_pc_plus4, if_instr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    step(); step();
    halt_req = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || halted !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL halt_enter got v=%b pc=%h h=%b addr=%h exp v=1 pc=8 h=1 addr=c", if_valid, if_pc, halted, imem_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'hC || if_instr !== 32'h0) begin
      errors++;
      $display("FAIL halt_hold got v=%b h=%b addr=%h ins=%h exp v=0 h=1 addr=c ins=0", if_valid, halted, imem_addr, if_instr);
    end
    halt_req = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL halt_resume got v=%b h=%b addr=%h exp v=0 h=0 addr=0", if_valid, halted, imem_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h8C00_0000) begin
      errors++;
      $display("FAIL halt_refetch got v=%b pc=%h ins=%h exp v=1 pc=0 ins=8c000000", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_fault();
    redirect = 1'b1; redirect_pc = 32'h1A; stall = 1'b1;
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL fault_enter got f=%b h=%b v=%b addr=%h exp f=1 h=1 v=0 addr=4", fault, halted, if_valid, imem_addr);
    end
    stall = 1'b0; redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL fault_sticky got f=%b h=%b v=%b addr=%h exp f=1 h=1 v=0 addr=4", fault, halted, if_valid, imem_addr);
    end
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    rst = 1'b0; redirect = 1'b0;
    checks++;
    if (fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset got f=%b h=%b addr=%h v=%b exp f=0 h=0 addr=0 v=0", fault, halted, imem_addr, if_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset got=%h exp=fffffff8", imem_addr2); end
    step();
    checks++;
    if (if_pc2 !== 32'hFFFF_FFF8 || if_pc_plus42 !== 32'hFFFF_FFFC || if_valid2 !== 1'b1) begin
      errors++; $display("FAIL wrap0 got pc=%h p4=%h exp pc=fffffff8 p4=fffffffc", if_pc2, if_pc_plus42);
    end
    step();
    checks++;
    if (if_pc2 !== 32'hFFFF_FFFC || if_pc_plus42 !== 32'h0 || imem_addr2 !== 32'h0) begin
      errors++; $display("FAIL wrap1 got pc=%h p4=%h addr=%h exp pc=fffffffc p4=0 addr=0", if_pc2, if_pc_plus42, imem_addr2);
    end
    step();
    checks++;
    if (if_pc2 !== 32'h0 || if_instr2 !== 32'h8C00_0000 || fault2 !== 1'b0 || halted2 !== 1'b0) begin
      errors++; $display("FAIL wrap2 got pc=%h ins=%h f=%b h=%b exp pc=0 ins=8c000000 f=0 h=0", if_pc2, if_instr2, fault2, halted2);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_halt();
    test_fault();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue CPU. Holds the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles decode/execute redirects (taken branch, jump), downstream stall, halt requests, and misaligned-target faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  current PC, fed to the instruction memory address input.
- imem_data  in  32  instruction word at imem_addr, combinational, valid in the same cycle.
- stall  in  1  downstream cannot accept; hold the PC and IF/ID contents.
- redirect  in  1  taken branch or jump, one-cycle pulse.
- redirect_pc  in  32  new PC when redirect=1.
- halt_req  in  1  stop fetching after the current cycle.
- if_valid  out  1  IF/ID register holds a real instruction.
- if_pc  out  32  PC of the instruction in IF/ID.
- if_pc_plus4  out  32  if_pc + 4, used for branch and jump target formation.
- if_instr  out  32  captured instruction; 32'h0 (NOP) when if_valid=0.
- halted  out  1  in HALT or FAULT.
- fault  out  1  sticky; a misaligned redirect was seen.

## Operation
- States:
  - RUN: fetch one word per cycle.
  - HALT: no fetch.
  - FAULT: terminal.
- Per-edge priority: rst > redirect > stall > halt_req > normal advance.
- RUN, normal advance:
  - IF/ID <= {valid=1, pc, pc+4, imem_data}.
  - pc <= pc+4.
- RUN, stall=1 and no redirect: pc and IF/ID hold their values.
- RUN, redirect with redirect_pc[1:0]==0:
  - pc <= redirect_pc.
  - IF/ID <= bubble (valid=0, instr=0). The wrong-path word in imem_data is discarded.
  - This applies even when stall=1.
- Redirect with redirect_pc[1:0]!=0, from any non-FAULT state:
  - Go to FAULT; fault <= 1.
  - IF/ID <= bubble; pc holds.
- RUN, halt_req=1 with no redirect or stall:
  - The current word is captured as normal.
  - pc <= pc+4, then go to HALT.
- HALT:
  - IF/ID <= bubble; pc holds.
  - An aligned redirect loads pc and returns to RUN. A bubble is inserted that cycle.
  - halt_req and stall are ignored.
- FAULT: all inputs except rst are ignored; IF/ID holds a bubble; pc holds.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000. No flag is raised on wrap.

## Timing
- Reset values:
  - pc = RESET_PC; imem_addr = RESET_PC.
  - if_valid = 0; if_pc = 0; if_pc_plus4 = 0; if_instr = 0.
  - halted = 0; fault = 0; state = RUN.
- imem_addr equals pc combinationally; no other output is combinational.
- Latency: the instruction at address A appears on if_instr one edge after imem_addr==A and stall==0.
- First valid fetch: the first edge with rst=0 gives if_valid=1 and if_pc=RESET_PC.
- Redirect penalty: exactly one bubble cycle. The target instruction appears on if_pc two edges after the redirect pulse.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values on that edge.
- halted rises on the edge that enters HALT or FAULT.

## Structure
- Shared package cpu_pkg:
  - fetch state enum (RUN, HALT, FAULT).
  - NOP_INSTR = 32'h0.
  - DEFAULT_RESET_PC.
  - IF/ID bundle typedef {valid, pc, pc_plus4, instr}, reused by the decode stage.
- One natural sub-module, if_id_reg: the pipeline register with hold (stall) and flush (bubble) controls. fetch_stage keeps the PC, next-PC mux and the FSM.

## Test plan
- Reset, then 4 free cycles against a ROM returning 0x8C000000, 0x20010005, 0x20020005, 0x00221820 at 0/4/8/C -> if_pc = 0, 4, 8, C with matching if_instr and if_valid=1; if_pc_plus4 = 4, 8, C, 10.
- stall=1 for 3 cycles while if_pc=4 -> if_pc, if_instr and imem_addr are constant for 3 cycles; resume at if_pc=8.
- redirect=1, redirect_pc=0x18 while imem_addr=0x14 -> the next edge gives if_valid=0 and if_instr=0; the following edge gives if_pc=0x18; 0x14 is never valid.
- redirect with redirect_pc=0x1A, same cycle stall=1 -> fault=1, halted=1, if_valid=0; later redirects are ignored until rst.
- halt_req at pc=8 -> 8 is captured valid, then halted=1 and if_valid=0 with pc=C; an aligned redirect to 0 resumes with if_pc=0 two edges later.
- Wrap-around with RESET_PC=32'hFFFF_FFF8 -> if_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000.
